key_debouncer: RTL and testbench
================================

// Module: key_debouncer
// PURPOSE
//  Conditions N raw push-button inputs (board KEY/SW pins) for the game logic. Per channel:
//   2-flop synchroniser, debounce FSM, clean level, one-cycle press/release strobes.
//  Sits directly upstream of the game-state registers; press[i] drives their enable inputs.
// PARAMETERS
//  N                1       number of button channels
//  DEBOUNCE_CYCLES  500000  consecutive stable clocks required to accept a change (10 ms @ 50 MHz); legal >= 1
//  ACTIVE_LOW       1       1: raw pin low = pressed; 0: raw pin high = pressed
// PORTS
//  clk       in   1  system clock; all state updates on rising edge
//  reset     in   1  synchronous, active-high; sampled on the rising edge of clk
//  raw_in    in   N  asynchronous button pins
//  level     out  N  debounced state, 1 = pressed
//  press     out  N  1-cycle strobe on accepted press
//  release   out  N  1-cycle strobe on accepted release
//  any_press out  1  OR-reduction of press; same cycle as press, no extra register
// BEHAVIOUR
//  - Normalise: p = ACTIVE_LOW ? ~raw_in : raw_in. Sync flops s1 <= p, s2 <= s1; FSM reads s2 only.
//  - Per-channel FSM. States: IDLE (released), PRESS_WAIT, HELD, RELEASE_WAIT.
//    Counter width = max(1, $clog2(DEBOUNCE_CYCLES)).
//   IDLE:         s2=1 -> PRESS_WAIT, cnt<=0; otherwise stay.
//   PRESS_WAIT:   s2=0 -> IDLE, cnt<=0, no strobe.
//                 s2=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD; level<=1, press<=1.
//                 Otherwise cnt<=cnt+1.
//   HELD:         s2=0 -> RELEASE_WAIT, cnt<=0.
//   RELEASE_WAIT: s2=1 -> HELD, cnt<=0, no strobe.
//                 s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; level<=0, release<=1.
//                 Otherwise cnt<=cnt+1.
//  - Strobes are registered and high for exactly one cycle; never both high on one channel.
//  - Latency: first edge sampling new raw value = edge 1. The strobe is high in the cycle after
//    edge 3+DEBOUNCE_CYCLES. level changes on the same edge as the strobe.
//  - Glitch rule: any bounce shorter than DEBOUNCE_CYCLES stable cycles produces no strobe and
//    no level change. A bounce inside a WAIT state restarts the count from 0.
//  - Channels are fully independent. Simultaneous events on several channels give simultaneous strobes.
//  - Reset (any cycle, including mid-WAIT): state IDLE, cnt 0, level/press/release 0.
//    s1/s2 <= 0 (released). The pending transition is abandoned and no strobe is emitted.
//    A button held through reset is debounced afresh after reset deasserts and yields one press.
//  - Counter never wraps: it is cleared on every state entry and saturates logically at the
//    compare value.
// STRUCTURE
//  - Shared constants file game_defs.vh: state codes KD_IDLE=2'd0, KD_PRESS_WAIT=2'd1,
//    KD_HELD=2'd2, KD_RELEASE_WAIT=2'd3.
//  - Sub-module key_debounce_channel: one channel = sync + FSM + counter, params DEBOUNCE_CYCLES.
//  - key_debouncer = ACTIVE_LOW normalisation, generate loop of N channels, any_press OR.
//  - Sync flops may reuse the codebase DFlipFlop (n=1) with the same reset.
// TESTING  (bench uses N=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
//  1 Clean press: raw_in[0] 1->0 held, first sampled at edge 1 -> press[0]=1 and any_press=1
//    only in the cycle after edge 7; level[0]=1 from edge 7; release[0] stays 0.
//  2 Bounce: raw_in[0] low 2 cycles, high 1, low held -> no strobe until 4 stable cycles.
//    Exactly one press, at edge 3+4 after the final low.
//  3 Release: from HELD, raw_in[0] 0->1 held -> release[0] pulses once; level[0]=0 on the
//    same edge; a 3-cycle release glitch gives no strobe.
//  4 Simultaneous: raw_in=2'b00 at the same edge -> press=2'b11 in the same cycle,
//    any_press=1 for one cycle.
//  5 Reset mid-PRESS_WAIT: assert reset at cnt=2 for 1 cycle with key held -> no strobe during
//    reset; all outputs 0; one press exactly 3+4 edges after reset deasserts.
//  6 Held key: raw_in[1]=0 held for 100 cycles -> exactly one press[1] and level[1]=1
//    throughout; no repeat strobes.

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: channel FSM state codes
// and counter sizing.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    KD_IDLE         = 2'd0,
    KD_PRESS_WAIT   = 2'd1,
    KD_HELD         = 2'd2,
    KD_RELEASE_WAIT = 2'd3
  } kd_state_t;

  // Stability counter width; never narrower than one bit so DEBOUNCE_CYCLES=1 still builds.
  function automatic int kd_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One button channel: two-flop synchroniser, debounce FSM with stability counter,
// registered clean level and one-cycle press/release strobes.
module key_debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic press,
  output logic release_strobe
);

  localparam int             CW       = kd_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            s1;
  logic            s2;
  kd_state_t       state;
  kd_state_t       state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic            level_next;
  logic            press_next;
  logic            release_next;

  // Synchroniser resets to "released" so a key held through reset is debounced afresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= KD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      KD_IDLE: begin
        if (s2) begin
          state_next = KD_PRESS_WAIT;
          cnt_next   = '0;
        end else begin
          state_next = KD_IDLE;
        end
      end
      KD_PRESS_WAIT: begin
        if (!s2) begin
          state_next = KD_IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = KD_HELD;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt + CW'(1);
        end
      end
      KD_HELD: begin
        if (!s2) begin
          state_next = KD_RELEASE_WAIT;
          cnt_next   = '0;
        end else begin
          state_next = KD_HELD;
        end
      end
      KD_RELEASE_WAIT: begin
        if (s2) begin
          state_next = KD_HELD;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = KD_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt + CW'(1);
        end
      end
      default: begin
        state_next = KD_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Strobes fire only on the accepting transition out of a WAIT state.
  always_comb begin
    level_next   = level;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      KD_IDLE:     level_next = 1'b0;
      KD_HELD:     level_next = 1'b1;
      KD_PRESS_WAIT: begin
        if (s2 && (cnt == CNT_LAST)) begin
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          level_next = 1'b0;
        end
      end
      KD_RELEASE_WAIT: begin
        if (!s2 && (cnt == CNT_LAST)) begin
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          level_next   = 1'b1;
        end
      end
      default:     level_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level          <= 1'b0;
      press          <= 1'b0;
      release_strobe <= 1'b0;
    end else begin
      level          <= level_next;
      press          <= press_next;
      release_strobe <= release_next;
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// N-channel push-button conditioner: polarity normalisation, independent
// debounce channels and an any-press summary.
module key_debouncer #(
  parameter int N               = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_strobe,
  output logic         any_press
);

  logic [N-1:0] pressed_raw;

  assign pressed_raw = ACTIVE_LOW ? ~raw_in : raw_in;

  for (genvar i = 0; i < N; i++) begin : g_chan
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk            (clk),
      .reset          (reset),
      .pin            (pressed_raw[i]),
      .level          (level[i]),
      .press          (press[i]),
      .release_strobe (release_strobe[i])
    );
  end

  // Combinational OR so any_press lines up with press in the same cycle.
  assign any_press = |press;

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a run-length
// debounce model; a monitor pops and compares every cycle.
module tb_key_debouncer;

  localparam int N = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] raw_in;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] release_strobe;
  logic         any_press;

  always #5 clk = ~clk;

  key_debouncer #(
    .N               (N),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .raw_in         (raw_in),
    .level          (level),
    .press          (press),
    .release_strobe (release_strobe),
    .any_press      (any_press)
  );

  typedef struct packed {
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic       any;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   started = 1'b0;
  bit   t6_window = 1'b0;
  int   t6_press = 0;

  // Reference model: a change is accepted once the synchronised input has
  // differed from the accepted level for D+1 consecutive clock edges.
  logic [1:0] m_d1 = 2'b00;
  logic [1:0] m_d2 = 2'b00;
  logic [1:0] m_level = 2'b00;
  int         m_run[2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  task automatic step(input logic [1:0] raw, input logic rst);
    exp_t       e;
    logic [1:0] p;
    @(negedge clk);
    raw_in = raw;
    reset  = rst;
    p      = ~raw;
    e      = '0;
    if (rst) begin
      m_d1    = 2'b00;
      m_d2    = 2'b00;
      m_level = 2'b00;
      m_run   = '{0, 0};
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (m_d2[ch] != m_level[ch]) m_run[ch]++;
        else                         m_run[ch] = 0;
        if (m_run[ch] == D + 1) begin
          m_level[ch] = ~m_level[ch];
          m_run[ch]   = 0;
          if (m_level[ch]) e.press[ch] = 1'b1;
          else             e.rel[ch]   = 1'b1;
        end
      end
      m_d2 = m_d1;
      m_d1 = p;
    end
    e.level = m_level;
    e.any   = |e.press;
    sb.push_back(e);
    started = 1'b1;
  endtask

  task automatic hold(input logic [1:0] raw, input logic rst, input int n);
    repeat (n) step(raw, rst);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("level",     32'(level),          32'(e.level));
        check("press",     32'(press),          32'(e.press));
        check("release",   32'(release_strobe), 32'(e.rel));
        check("any_press", 32'(any_press),      32'(e.any));
        if (t6_window && press[1]) t6_press++;
      end else if (started) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow at %0t: got empty queue want entry", $time);
      end
    end
  end

  initial begin : driver
    logic [31:0] r;
    int          len;
    logic        rst;
    raw_in = 2'b11;
    reset  = 1'b1;
    hold(2'b11, 1'b1, 3);
    hold(2'b11, 1'b0, 3);
    // clean press on channel 0, then release with a 3-cycle glitch first
    hold(2'b10, 1'b0, 12);
    hold(2'b11, 1'b0, 3);
    hold(2'b10, 1'b0, 8);
    hold(2'b11, 1'b0, 12);
    // bounce: low 2, high 1, low held
    hold(2'b10, 1'b0, 2);
    hold(2'b11, 1'b0, 1);
    hold(2'b10, 1'b0, 12);
    hold(2'b11, 1'b0, 12);
    // simultaneous press on both channels
    hold(2'b00, 1'b0, 12);
    hold(2'b11, 1'b0, 12);
    // reset in the middle of PRESS_WAIT with the key held
    hold(2'b10, 1'b0, 5);
    hold(2'b10, 1'b1, 1);
    hold(2'b10, 1'b0, 12);
    hold(2'b11, 1'b0, 12);
    // long hold on channel 1: one press only
    t6_window = 1'b1;
    hold(2'b01, 1'b0, 100);
    hold(2'b11, 1'b0, 12);
    t6_window = 1'b0;
    check("held_key_single_press", 32'(t6_press), 32'd1);
    // random bouncing with occasional reset
    repeat (300) begin
      r   = $urandom;
      len = $urandom_range(1, 8);
      rst = ($urandom_range(0, 99) == 0);
      hold(r[1:0], rst, rst ? 1 : len);
    end
    hold(2'b11, 1'b0, 12);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
